decode: RTL and testbench

Serial frame decoder for the FSK link; it is the receive-side counterpart of `encode`. The block hunts the incoming bit stream for the 3-bit preamble `110` and captures the following 7-bit Hamming(7,4) codeword. It corrects any single-bit error and presents the recovered 4-bit nibble with a one-cycle valid strobe. It sits after the demodulator/bit slicer, on the same clock as the transmit path.

---
 rtl/fsk_pkg.sv | 32 +++
 rtl/hamming74_correct.sv | 27 ++
 rtl/decode.sv | 79 +++++++
 tb/tb_decode.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared FSK link definitions: receive FSM states, frame geometry and the
// Hamming(7,4) syndrome column for each codeword bit (same equations as encode).
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE1 = 2'd1,
        ST_PRE2 = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [2:0] PREAMBLE = 3'b110;
    localparam int         CW_BITS  = 7;
    localparam logic [2:0] CNT_LAST = 3'(CW_BITS - 1);

    // Syndrome {s1,s2,s3} produced by a single error at each codeword bit.
    localparam logic [2:0] SYN_D3 = 3'b111;
    localparam logic [2:0] SYN_D2 = 3'b110;
    localparam logic [2:0] SYN_D1 = 3'b101;
    localparam logic [2:0] SYN_D0 = 3'b011;
    localparam logic [2:0] SYN_P1 = 3'b100;
    localparam logic [2:0] SYN_P2 = 3'b010;
    localparam logic [2:0] SYN_P3 = 3'b001;

    // Codeword layout MSB-first: {d3,d2,d1,d0,p1,p2,p3}.
    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        return {cw[2] ^ cw[6] ^ cw[5] ^ cw[4],
                cw[1] ^ cw[6] ^ cw[5] ^ cw[3],
                cw[0] ^ cw[6] ^ cw[4] ^ cw[3]};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector: codeword in, corrected
// nibble and nonzero-syndrome flag out.
module hamming74_correct
    import fsk_pkg::*;
(
    input  logic [6:0] codeword,
    output logic [3:0] data,
    output logic       err
);

    logic [2:0] syn;

    always_comb begin
        syn  = syndrome(codeword);
        data = codeword[6:3];
        // Parity-only syndromes leave the nibble untouched.
        case (syn)
            SYN_D3:  data[3] = ~codeword[6];
            SYN_D2:  data[2] = ~codeword[5];
            SYN_D1:  data[1] = ~codeword[4];
            SYN_D0:  data[0] = ~codeword[3];
            default: data    = codeword[6:3];
        endcase
        err = (syn != 3'b000);
    end

endmodule

// File: rtl/decode.sv
// FSK receive framer: hunts for the 110 preamble, shifts in a 7-bit Hamming
// codeword and presents the corrected nibble with a one-cycle valid strobe.
module decode
    import fsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    input  logic       decode_en,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       err_flag
);

    state_t     state;
    logic [2:0] cnt;
    // Holds the first six codeword bits; the seventh is taken straight from
    // data_in so the result registers on the same edge that samples it.
    logic [5:0] shreg;
    logic [6:0] cw_next;
    logic [3:0] corr_data;
    logic       corr_err;

    assign cw_next = {shreg, data_in};

    hamming74_correct u_correct (
        .codeword (cw_next),
        .data     (corr_data),
        .err      (corr_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            shreg      <= 6'd0;
            data_out   <= 4'h0;
            data_valid <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (decode_en && (data_in == PREAMBLE[2]))
                        state <= ST_PRE1;
                end
                ST_PRE1: begin
                    if (decode_en && (data_in == PREAMBLE[1]))
                        state <= ST_PRE2;
                    else
                        state <= ST_IDLE;
                end
                ST_PRE2: begin
                    // A longer run of 1s just keeps us waiting for the 0.
                    if (!decode_en) begin
                        state <= ST_IDLE;
                    end else if (data_in == PREAMBLE[0]) begin
                        state <= ST_DATA;
                        cnt   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg <= cw_next[5:0];
                    if (cnt == CNT_LAST) begin
                        data_out   <= corr_data;
                        err_flag   <= corr_err;
                        data_valid <= 1'b1;
                        cnt        <= 3'd0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the FSK frame decoder: clean, corrected, false-preamble,
// back-to-back, mid-frame reset and disabled-decoder frames.
module tb_decode;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic       decode_en;
    logic [3:0] data_out;
    logic       data_valid;
    logic       err_flag;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    int         obs_t[$];

    // Frames MSB-first: preamble, d3..d0, p1,p2,p3.
    localparam logic [9:0] F_1011       = 10'b110_1011_001;
    localparam logic [9:0] F_0000_FAULT = 10'b110_0010_000;
    localparam logic [9:0] F_1011_P2    = 10'b110_1011_011;
    localparam logic [9:0] F_0110       = 10'b110_0110_011;
    localparam logic [9:0] F_0101       = 10'b110_0101_101;

    decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .decode_en  (decode_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_flag   (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            obs_q.push_back({data_out, err_flag});
            obs_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b);
        @(negedge clk);
        data_in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0);
    endtask

    task automatic send_frame(input logic [9:0] f, output int last);
        for (int i = 9; i >= 0; i--) drive(f[i]);
        last = cyc;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_value"}, obs_q.pop_front(), exp_q.pop_front());
        clear_obs();
    endtask

    initial begin
        int last;
        int last2;

        rst_n     = 1'b0;
        data_in   = 1'b0;
        decode_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 4'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_err", err_flag, 1'b0);
        check("rst_state", {30'b0, dut.state}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Clean frame, strobe in the cycle right after the last bit's edge.
        clear_obs();
        exp_q.push_back({4'b1011, 1'b0});
        send_frame(F_1011, last);
        idle(4);
        if (obs_t.size() > 0) check("clean_time", obs_t[0], last + 1);
        else check("clean_time_missing", 0, 1);
        check_strobes("clean");

        // Encoder fault injection: d1 inverted, syndrome 101.
        exp_q.push_back({4'b0000, 1'b1});
        send_frame(F_0000_FAULT, last);
        idle(4);
        check_strobes("fault_d1");

        // Parity bit p2 flipped, data untouched.
        exp_q.push_back({4'b1011, 1'b1});
        send_frame(F_1011_P2, last);
        idle(4);
        check_strobes("parity_p2");

        // False preamble 1,0 then 1,1,1,0 before the codeword.
        exp_q.push_back({4'b0110, 1'b0});
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        send_frame(F_0110, last);
        idle(4);
        check_strobes("false_pre");

        // Back-to-back frames separated by one idle 0.
        exp_q.push_back({4'b1011, 1'b0});
        exp_q.push_back({4'b0101, 1'b0});
        send_frame(F_1011, last);
        drive(1'b0);
        send_frame(F_0101, last2);
        idle(4);
        check("b2b_last_gap", last2 - last, 11);
        if (obs_t.size() == 2) check("b2b_spacing", obs_t[1] - obs_t[0], 11);
        else check("b2b_spacing_count", obs_t.size(), 2);
        check_strobes("b2b");

        // Reset after the 4th codeword bit aborts the frame.
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        @(negedge clk);
        rst_n   = 1'b0;
        data_in = 1'b0;
        #1;
        check("abort_data_out", data_out, 4'h0);
        check("abort_valid", data_valid, 1'b0);
        check("abort_err", err_flag, 1'b0);
        check("abort_state", {30'b0, dut.state}, 32'd0);
        check("abort_cnt", {29'b0, dut.cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check("abort_idle_state", {30'b0, dut.state}, 32'd0);
        check("abort_idle_data", data_out, 4'h0);
        check_strobes("abort");

        exp_q.push_back({4'b1011, 1'b0});
        send_frame(F_1011, last);
        idle(4);
        check_strobes("after_abort");

        // Decoder disabled: a complete frame is ignored.
        decode_en = 1'b0;
        send_frame(F_0101, last);
        idle(4);
        check_strobes("disabled");
        check("disabled_hold", data_out, 4'b1011);
        decode_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
